// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: default widths,
// FSM state encoding and the byte-per-word constant.
package imem_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int WORD_W_DEF     = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CSUM = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and memory write bus of the loader.
// master: program source / memory side; slave: the loader itself.
interface imem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport master (
        output in_byte, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_byte, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes big-endian into a word. The first three bytes sit in a
// 24-bit shift register; the fourth completes the word, which is registered
// together with a one-cycle word_valid pulse.
module imem_byte_packer
    import imem_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        idx;
    logic [WORD_W-9:0] sr;

    // Byte index, shift register and registered word output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            sr         <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                idx <= '0;
                sr  <= '0;
            end else if (byte_en) begin
                sr  <= {sr[WORD_W-17:0], byte_in};
                idx <= idx + 2'd1;
                if (idx == 2'(BYTES_PER_WORD - 1)) begin
                    word       <= {sr, byte_in};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams a program in byte by byte, writes packed
// words to consecutive addresses from 0 and holds the CPU while doing so.
// Optional trailer checksum enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ADDR_W:0] word_count,
    imem_loader_if.slave    bus,
    output logic            busy,
    output logic            done,
    output logic            cpu_hold,
    output logic            err
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W:0]   words_left;
    logic [ADDR_W-1:0] addr;
    logic              start_acc;
    logic              byte_acc;
    logic              word_valid;
    logic [WORD_W-1:0] word;
    logic              last_word;

    assign start_acc = (state == S_IDLE) && start;
    assign byte_acc  = bus.in_valid && bus.in_ready;
    assign last_word = word_valid && (words_left == ONE_WORD);

    imem_byte_packer #(.WORD_W(WORD_W)) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_acc),
        .byte_en    (byte_acc && (state == S_LOAD)),
        .byte_in    (bus.in_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and Moore outputs; the write bubble drops in_ready for a cycle.
    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        case (state)
            S_IDLE: if (start) state_nxt = (word_count == '0) ? S_DONE : S_LOAD;
            S_LOAD: begin
                bus.in_ready = !word_valid;
`ifdef IMEM_LOADER_CSUM_EN
                if (last_word) state_nxt = S_CSUM;
`else
                if (last_word) state_nxt = S_DONE;
`endif
            end
            S_CSUM: begin
                bus.in_ready = 1'b1;
                if (byte_acc) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cpu_hold    = busy;
    assign bus.wr_en   = word_valid;
    assign bus.wr_data = word;
    assign bus.wr_addr = addr;

    // Word countdown and write address; address stays on the last word instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_left <= '0;
            addr       <= '0;
        end else if (start_acc) begin
            words_left <= word_count[ADDR_W] ? MAX_WORDS : word_count;
            addr       <= '0;
        end else if (word_valid) begin
            words_left <= words_left - ONE_WORD;
            if (!last_word) addr <= addr + ADDR_W'(1);
        end
    end

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] sum;

    // Running byte sum; the trailer must bring it to zero, otherwise err sticks until next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            err <= 1'b0;
        end else if (start_acc) begin
            sum <= '0;
            err <= 1'b0;
        end else if (byte_acc && (state == S_LOAD)) begin
            sum <= sum + bus.in_byte;
        end else if (byte_acc && (state == S_CSUM)) begin
            err <= ((sum + bus.in_byte) != 8'h00);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; checksum scenario runs when
// IMEM_LOADER_CSUM_EN is defined.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [8:0] word_count = '0;
    logic       busy, done, cpu_hold, err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    logic [7:0]  q_addr[$];
    logic [31:0] q_data[$];

    imem_loader_if #(.ADDR_W(8), .WORD_W(32)) bus();

    imem_loader #(.ADDR_W(8), .WORD_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .cpu_hold   (cpu_hold),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Write/done monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                q_addr.push_back(bus.wr_addr);
                q_data.push_back(bus.wr_data);
            end
            if (done) n_done++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [8:0] wc);
        start = 1'b1;
        word_count = wc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_byte = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_byte %h: in_ready never high", b);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (n_done == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        n_cmp++;
        if (n_done !== 1) begin n_bad++; $display("FAIL wait_done: done pulses %0d, want 1", n_done); end
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.wr_en, busy, done, cpu_hold, err} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 000000",
                              {bus.in_ready, bus.wr_en, busy, done, cpu_hold, err});
        end
        n_cmp++;
        if ({bus.wr_addr, bus.wr_data} !== 40'h0) begin
            n_bad++; $display("FAIL reset_bus: got %h want 0", {bus.wr_addr, bus.wr_data});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, busy, bus.wr_en} !== 3'b000) begin
            n_bad++; $display("FAIL idle_after_reset: got %b want 000", {bus.in_ready, busy, bus.wr_en});
        end
    endtask

    task automatic test_basic();
        logic [7:0] b[8] = '{8'h02, 8'h32, 8'h80, 8'h20, 8'h22, 8'h30, 8'h00, 8'h03};
        do_start(9'd2);
        n_cmp++;
        if ({busy, cpu_hold, bus.in_ready} !== 3'b111) begin
            n_bad++; $display("FAIL basic_load_flags: got %b want 111", {busy, cpu_hold, bus.in_ready});
        end
        for (int i = 0; i < 4; i++) send_byte(b[i]);
        @(negedge clk);
        n_cmp++;
        if ({bus.wr_en, bus.in_ready, bus.wr_addr, bus.wr_data} !== {2'b10, 8'h00, 32'h02328020}) begin
            n_bad++; $display("FAIL basic_word0: got en=%b rdy=%b addr=%h data=%h want en=1 rdy=0 addr=00 data=02328020",
                              bus.wr_en, bus.in_ready, bus.wr_addr, bus.wr_data);
        end
        for (int i = 4; i < 8; i++) send_byte(b[i]);
        @(negedge clk);
        n_cmp++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 8'h01, 32'h22300003}) begin
            n_bad++; $display("FAIL basic_word1: got en=%b addr=%h data=%h want en=1 addr=01 data=22300003",
                              bus.wr_en, bus.wr_addr, bus.wr_data);
        end
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'hD7);
`endif
        @(negedge clk);
        n_cmp++;
        if ({done, busy, bus.wr_en} !== 3'b110) begin
            n_bad++; $display("FAIL basic_done: got done/busy/wr_en=%b want 110", {done, busy, bus.wr_en});
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy, cpu_hold, err} !== 4'b0000) begin
            n_bad++; $display("FAIL basic_idle: got done/busy/hold/err=%b want 0000", {done, busy, cpu_hold, err});
        end
    endtask

    task automatic test_zero();
        do_start(9'd0);
        n_cmp++;
        if ({done, busy, bus.wr_en} !== 3'b110) begin
            n_bad++; $display("FAIL zero_done: got done/busy/wr_en=%b want 110", {done, busy, bus.wr_en});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, busy, bus.wr_en} !== 3'b000) begin
            n_bad++; $display("FAIL zero_after: got done/busy/wr_en=%b want 000", {done, busy, bus.wr_en});
        end
    endtask

    task automatic test_gaps();
        logic [7:0] b[8] = '{8'h02, 8'h32, 8'h80, 8'h20, 8'h22, 8'h30, 8'h00, 8'h03};
        q_addr.delete(); q_data.delete(); n_done = 0;
        do_start(9'd2);
        for (int i = 0; i < 8; i++) begin
            send_byte(b[i]);
            if (i == 5) begin start = 1'b1; word_count = 9'd5; end
            @(posedge clk); #1;
            start = 1'b0;
        end
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'hD7);
`endif
        wait_done();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q_addr.size() !== 2) begin
            n_bad++; $display("FAIL gaps_count: got %0d writes want 2", q_addr.size());
        end else begin
            n_cmp++;
            if ({q_addr[0], q_data[0], q_addr[1], q_data[1]} !== {8'h00, 32'h02328020, 8'h01, 32'h22300003}) begin
                n_bad++; $display("FAIL gaps_words: got %h:%h %h:%h want 00:02328020 01:22300003",
                                  q_addr[0], q_data[0], q_addr[1], q_data[1]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL gaps_start_ignored: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        do_start(9'd2);
        send_byte(8'h02);
        send_byte(8'h32);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.wr_en, busy, done, cpu_hold, err, bus.wr_addr} !== 14'h0) begin
            n_bad++; $display("FAIL midreset_outputs: got %b want 0",
                              {bus.in_ready, bus.wr_en, busy, done, cpu_hold, err, bus.wr_addr});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(9'd1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        @(negedge clk);
        n_cmp++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 8'h00, 32'hAABBCCDD}) begin
            n_bad++; $display("FAIL midreset_reload: got en=%b addr=%h data=%h want en=1 addr=00 data=AABBCCDD",
                              bus.wr_en, bus.wr_addr, bus.wr_data);
        end
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'hF2);
`endif
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL midreset_done: done=%b want 1", done); end
        @(negedge clk);
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_csum();
        do_start(9'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hF6);
        @(negedge clk);
        n_cmp++;
        if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL csum_good: done/err=%b want 10", {done, err}); end
        @(negedge clk);
        do_start(9'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hF5);
        @(negedge clk);
        n_cmp++;
        if ({done, err} !== 2'b11) begin n_bad++; $display("FAIL csum_bad: done/err=%b want 11", {done, err}); end
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({busy, err} !== 2'b01) begin n_bad++; $display("FAIL csum_sticky: busy/err=%b want 01", {busy, err}); end
        do_start(9'd0);
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL csum_clear: err=%b want 0", err); end
        @(negedge clk);
    endtask
`endif

    task automatic test_clamp();
        q_addr.delete(); q_data.delete(); n_done = 0;
        do_start(9'h1FF);
        for (int k = 0; k < 1024; k++) send_byte(8'(k));
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(8'h00);
`endif
        wait_done();
        n_cmp++;
        if (q_addr.size() !== 256) begin
            n_bad++; $display("FAIL clamp_count: got %0d writes want 256", q_addr.size());
        end else begin
            n_cmp++;
            if ({q_addr[0], q_data[0]} !== {8'h00, 32'h00010203}) begin
                n_bad++; $display("FAIL clamp_first: got %h:%h want 00:00010203", q_addr[0], q_data[0]);
            end
            n_cmp++;
            if ({q_addr[255], q_data[255]} !== {8'hFF, 32'hFCFDFEFF}) begin
                n_bad++; $display("FAIL clamp_last: got %h:%h want FF:FCFDFEFF", q_addr[255], q_data[255]);
            end
        end
        n_cmp++;
        if ({bus.wr_addr, err, busy} !== {8'hFF, 2'b00}) begin
            n_bad++; $display("FAIL clamp_nowrap: got addr=%h err=%b busy=%b want FF 0 0", bus.wr_addr, err, busy);
        end
    endtask

    initial begin
        bus.in_byte = '0;
        bus.in_valid = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_gaps();
        test_reset_mid();
`ifdef IMEM_LOADER_CSUM_EN
        test_csum();
`endif
        test_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
